note_ram_arbiter: RTL and testbench

Controller for the note RAM: owns its read and write ports and shares them between the recording FSM and the playback/draw FSM. Also runs a self-timed clear sequence that zeroes every note slot before a new recording. Sits between mainStateHandler-style requesters and NoteStorage; requesters never drive NoteStorage directly.

---
 rtl/note_ram_pkg.sv | 48 ++++
 rtl/note_read_rr_arbiter.sv | 33 +++
 rtl/note_ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_note_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_ram_pkg.sv
// Shared definitions for the note RAM controller: geometry, note field layout, requester and state encodings.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package note_ram_pkg;

    localparam int DATA_W = 62;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 101;

    // Note word layout: id | start time (us) | end time (us)
    localparam int NOTE_ID_HI = 61;
    localparam int NOTE_ID_LO = 58;
    localparam int T_START_HI = 57;
    localparam int T_START_LO = 29;
    localparam int T_END_HI   = 28;
    localparam int T_END_LO   = 0;

    typedef logic [DATA_W-1:0] noteWord_t;
    typedef logic [ADDR_W-1:0] noteAddr_t;

    // Requester index doubles as the bit position in the read req/gnt vectors
    typedef enum logic {
        REQ_REC = 1'b0,
        REQ_PB  = 1'b1
    } reqSel_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arbState_t;

    function automatic logic addrInRange(input noteAddr_t addr);
        return addr < noteAddr_t'(DEPTH);
    endfunction

    function automatic logic [NOTE_ID_HI-NOTE_ID_LO:0] noteId(input noteWord_t w);
        return w[NOTE_ID_HI:NOTE_ID_LO];
    endfunction

    function automatic logic [T_START_HI-T_START_LO:0] noteStart(input noteWord_t w);
        return w[T_START_HI:T_START_LO];
    endfunction

    function automatic logic [T_END_HI-T_END_LO:0] noteEnd(input noteWord_t w);
        return w[T_END_HI:T_END_LO];
    endfunction

endpackage

// File: rtl/note_read_rr_arbiter.sv
// Two-way round-robin arbiter for the note RAM read port (recorder vs playback).
// Latency: grant is combinational from req in the same cycle; the tie pointer updates at the clock edge.
// Backpressure: a lone requester is always granted; on a tie the loser holds its request and wins the next tie.
module note_read_rr_arbiter
    import note_ram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester that wins the next tie; recorder is favoured out of reset
    reqSel_t favoured;

    // Grant a lone requester directly, otherwise the favoured one
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (favoured == REQ_REC) ? 2'b01 : 2'b10;
        end
    end

    // Only contested cycles move the pointer, so an uncontested stream never steals priority
    always_ff @(posedge clk) begin
        if (reset) begin
            favoured <= REQ_REC;
        end else if (req == 2'b11) begin
            favoured <= (favoured == REQ_REC) ? REQ_PB : REQ_REC;
        end
    end

endmodule

// File: rtl/note_ram_arbiter.sv
// Note RAM controller: shares NoteStorage ports between recorder and playback and runs the slot-clear sequence.
// Latency: grants same cycle, read data/valid one cycle after grant, writes land at the edge ending the grant.
// Backpressure: no grants during CLEAR or reset; requesters hold requests until granted.
module note_ram_arbiter
    import note_ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,

    input  logic              rec_rd_req,
    input  logic [ADDR_W-1:0] rec_rd_addr,
    output logic              rec_rd_gnt,
    output logic              rec_rvalid,
    input  logic              rec_wr_req,
    input  logic [ADDR_W-1:0] rec_wr_addr,
    input  logic [DATA_W-1:0] rec_wdata,
    output logic              rec_wr_gnt,

    input  logic              pb_rd_req,
    input  logic [ADDR_W-1:0] pb_rd_addr,
    output logic              pb_rd_gnt,
    output logic              pb_rvalid,

    output logic [DATA_W-1:0] rdata,
    output logic              addr_err,

    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arbState_t state;
    arbState_t stateNext;
    noteAddr_t clearCnt;

    logic      runGate;
    logic      lastClear;
    logic [1:0] rdReq;
    logic [1:0] rdGnt;
    logic      rdAny;
    noteAddr_t rdAddr;
    logic      rdInRange;
    logic      wrInRange;
    logic      wrEffective;
    logic      fwdHit;

    // Registered read-return context, captured with the grant
    logic      rdValidQ;
    reqSel_t   ownerQ;
    logic      zeroQ;
    logic      fwdQ;
    noteWord_t fwdDataQ;
    logic      addrErrQ;
    logic      clearDoneQ;

    // Grants exist only in RUN and never while reset is held, so outputs sit at reset values
    assign runGate   = (state == RUN) && !reset;
    assign lastClear = (state == CLEAR) && (clearCnt == noteAddr_t'(DEPTH - 1));

    assign rdReq = {pb_rd_req, rec_rd_req} & {2{runGate}};

    note_read_rr_arbiter u_rdArb (
        .clk   (clk),
        .reset (reset),
        .req   (rdReq),
        .gnt   (rdGnt)
    );

    assign rec_rd_gnt = rdGnt[REQ_REC];
    assign pb_rd_gnt  = rdGnt[REQ_PB];
    assign rec_wr_gnt = rec_wr_req && runGate;

    assign rdAny       = |rdGnt;
    assign rdAddr      = rdGnt[REQ_PB] ? pb_rd_addr : rec_rd_addr;
    assign rdInRange   = addrInRange(rdAddr);
    assign wrInRange   = addrInRange(rec_wr_addr);
    assign wrEffective = rec_wr_gnt && wrInRange;
    // RAM read port returns the old word on a same-address collision, so bypass the write data
    assign fwdHit      = rdAny && rdInRange && wrEffective && (rec_wr_addr == rdAddr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: clear_start only matters in RUN, so a pulse during CLEAR is ignored
    always_comb begin
        stateNext = state;
        unique case (state)
            RUN:     if (clear_start) stateNext = CLEAR;
            CLEAR:   if (lastClear)   stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    // FSM outputs: RAM port steering and busy flag
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = '0;
        ram_wdata   = '0;
        ram_rd_addr = '0;
        clear_busy  = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    ram_we      = wrEffective;
                    ram_wr_addr = rec_wr_gnt ? rec_wr_addr : '0;
                    ram_wdata   = rec_wr_gnt ? rec_wdata : '0;
                    ram_rd_addr = (rdAny && rdInRange) ? rdAddr : '0;
                end
                CLEAR: begin
                    ram_we      = 1'b1;
                    ram_wr_addr = clearCnt;
                    clear_busy  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear counter sits at zero in RUN so CLEAR always starts from slot 0
    always_ff @(posedge clk) begin
        if (reset || (state == RUN)) begin
            clearCnt <= '0;
        end else begin
            clearCnt <= clearCnt + noteAddr_t'(1);
        end
    end

    // Capture owner, zero/forward selection and pulse flags alongside the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rdValidQ   <= 1'b0;
            ownerQ     <= REQ_REC;
            zeroQ      <= 1'b0;
            fwdQ       <= 1'b0;
            fwdDataQ   <= '0;
            addrErrQ   <= 1'b0;
            clearDoneQ <= 1'b0;
        end else begin
            rdValidQ   <= rdAny;
            ownerQ     <= rdGnt[REQ_PB] ? REQ_PB : REQ_REC;
            zeroQ      <= rdAny && !rdInRange;
            fwdQ       <= fwdHit;
            if (fwdHit) begin
                fwdDataQ <= rec_wdata;
            end
            addrErrQ   <= (rdAny && !rdInRange) || (rec_wr_gnt && !wrInRange);
            clearDoneQ <= lastClear;
        end
    end

    assign rec_rvalid = rdValidQ && (ownerQ == REQ_REC);
    assign pb_rvalid  = rdValidQ && (ownerQ == REQ_PB);
    assign addr_err   = addrErrQ;
    assign clear_done = clearDoneQ;

    // Read data mux: out-of-range reads return zero, collisions return the forwarded word
    always_comb begin
        rdata = '0;
        if (rdValidQ) begin
            if (zeroQ) begin
                rdata = '0;
            end else if (fwdQ) begin
                rdata = fwdDataQ;
            end else begin
                rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_note_ram_arbiter.sv
// Directed bench for note_ram_arbiter with a behavioural NoteStorage model.
// Latency: inputs change 1 time unit after posedge; outputs sampled there too.
// Backpressure: n/a.
module tb_note_ram_arbiter;
    import note_ram_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              rec_rd_req;
    logic [ADDR_W-1:0] rec_rd_addr;
    logic              rec_rd_gnt;
    logic              rec_rvalid;
    logic              rec_wr_req;
    logic [ADDR_W-1:0] rec_wr_addr;
    logic [DATA_W-1:0] rec_wdata;
    logic              rec_wr_gnt;
    logic              pb_rd_req;
    logic [ADDR_W-1:0] pb_rd_addr;
    logic              pb_rd_gnt;
    logic              pb_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              addr_err;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:127];

    int nRun  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    note_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .rec_rd_req  (rec_rd_req),
        .rec_rd_addr (rec_rd_addr),
        .rec_rd_gnt  (rec_rd_gnt),
        .rec_rvalid  (rec_rvalid),
        .rec_wr_req  (rec_wr_req),
        .rec_wr_addr (rec_wr_addr),
        .rec_wdata   (rec_wdata),
        .rec_wr_gnt  (rec_wr_gnt),
        .pb_rd_req   (pb_rd_req),
        .pb_rd_addr  (pb_rd_addr),
        .pb_rd_gnt   (pb_rd_gnt),
        .pb_rvalid   (pb_rvalid),
        .rdata       (rdata),
        .addr_err    (addr_err),
        .ram_rd_addr (ram_rd_addr),
        .ram_wr_addr (ram_wr_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    // NoteStorage model: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wdata;
        ram_rdata <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nRun++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wrSlot(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rec_wr_req  = 1'b1;
        rec_wr_addr = a;
        rec_wdata   = d;
        step();
        rec_wr_req  = 1'b0;
    endtask

    task automatic rdSlot(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        rec_rd_req  = 1'b1;
        rec_rd_addr = a;
        step();
        rec_rd_req  = 1'b0;
        d = rdata;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] wordA;
        logic [DATA_W-1:0] wordB;
        int busyCnt;
        int doneCnt;
        int gntBusy;
        int nonZero;

        reset = 1'b1; clear_start = 1'b0;
        rec_rd_req = 1'b0; rec_rd_addr = '0;
        rec_wr_req = 1'b0; rec_wr_addr = '0; rec_wdata = '0;
        pb_rd_req = 1'b0; pb_rd_addr = '0;

        // Reset state, with a write request held to confirm no grant leaks through reset
        step();
        rec_wr_req = 1'b1; rec_wr_addr = 7'd3; rec_wdata = 62'h55;
        step();
        chk("rst_wr_gnt",   64'(rec_wr_gnt), 64'd0);
        chk("rst_ram_we",   64'(ram_we),     64'd0);
        chk("rst_rvalid",   64'({rec_rvalid, pb_rvalid}), 64'd0);
        chk("rst_rdata",    64'(rdata),      64'd0);
        chk("rst_busy",     64'(clear_busy), 64'd0);
        chk("rst_done",     64'(clear_done), 64'd0);
        chk("rst_addr_err", 64'(addr_err),   64'd0);
        rec_wr_req = 1'b0;
        reset = 1'b0;
        step();

        // Basic write then read-back at addr 5
        rec_wr_req = 1'b1; rec_wr_addr = 7'd5; rec_wdata = 62'h3_0000001_0000000;
        #1;
        chk("wr5_gnt",  64'(rec_wr_gnt),  64'd1);
        chk("wr5_we",   64'(ram_we),      64'd1);
        chk("wr5_addr", 64'(ram_wr_addr), 64'd5);
        step();
        rec_wr_req = 1'b0;
        rec_rd_req = 1'b1; rec_rd_addr = 7'd5;
        #1;
        chk("rd5_gnt", 64'(rec_rd_gnt), 64'd1);
        step();
        rec_rd_req = 1'b0;
        chk("rd5_rvalid", 64'(rec_rvalid), 64'd1);
        chk("rd5_pbval",  64'(pb_rvalid),  64'd0);
        chk("rd5_data",   64'(rdata),      64'h3_0000001_0000000);

        // Round-robin: both held four cycles, recorder wins the first tie
        wordA = 62'hA0A;
        wordB = 62'hB0B;
        wrSlot(7'd10, wordA);
        wrSlot(7'd11, wordB);
        rec_rd_req = 1'b1; rec_rd_addr = 7'd10;
        pb_rd_req  = 1'b1; pb_rd_addr  = 7'd11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_rec_gnt", 64'(rec_rd_gnt), 64'((k % 2) == 0));
            chk("rr_pb_gnt",  64'(pb_rd_gnt),  64'((k % 2) == 1));
            step();
            chk("rr_rec_rvalid", 64'(rec_rvalid), 64'((k % 2) == 0));
            chk("rr_pb_rvalid",  64'(pb_rvalid),  64'((k % 2) == 1));
            chk("rr_rdata",      64'(rdata),      64'(((k % 2) == 0) ? wordA : wordB));
        end
        rec_rd_req = 1'b0; pb_rd_req = 1'b0;

        // Same-cycle write and read of addr 9 returns the new word
        wrSlot(7'd9, 62'h5555);
        rec_wr_req = 1'b1; rec_wr_addr = 7'd9; rec_wdata = 62'h1234;
        rec_rd_req = 1'b1; rec_rd_addr = 7'd9;
        #1;
        chk("fwd_wr_gnt", 64'(rec_wr_gnt), 64'd1);
        chk("fwd_rd_gnt", 64'(rec_rd_gnt), 64'd1);
        step();
        rec_wr_req = 1'b0; rec_rd_req = 1'b0;
        chk("fwd_rvalid", 64'(rec_rvalid), 64'd1);
        chk("fwd_rdata",  64'(rdata),      64'h1234);
        rdSlot(7'd9, d);
        chk("fwd_landed", 64'(d), 64'h1234);

        // Out-of-range write at 101 and read at 120
        rec_wr_req = 1'b1; rec_wr_addr = 7'd101; rec_wdata = 62'h77;
        #1;
        chk("oor_wr_gnt", 64'(rec_wr_gnt), 64'd1);
        chk("oor_wr_we",  64'(ram_we),     64'd0);
        step();
        rec_wr_req = 1'b0;
        chk("oor_wr_err", 64'(addr_err), 64'd1);
        step();
        chk("oor_err_pulse", 64'(addr_err), 64'd0);
        pb_rd_req = 1'b1; pb_rd_addr = 7'd120;
        #1;
        chk("oor_rd_gnt", 64'(pb_rd_gnt), 64'd1);
        step();
        pb_rd_req = 1'b0;
        chk("oor_rd_rvalid", 64'(pb_rvalid), 64'd1);
        chk("oor_rd_rdata",  64'(rdata),     64'd0);
        chk("oor_rd_err",    64'(addr_err),  64'd1);

        // Fill every slot, then clear with an in-flight read and requests held throughout
        for (int i = 0; i < DEPTH; i++) wrSlot(7'(i), 62'h100 + 62'(i));
        rdSlot(7'd100, d);
        chk("fill_last_slot", 64'(d), 64'h164);
        clear_start = 1'b1;
        rec_rd_req = 1'b1; rec_rd_addr = 7'd7;
        #1;
        chk("clr_inflight_gnt", 64'(rec_rd_gnt), 64'd1);
        step();
        clear_start = 1'b0;
        chk("clr_inflight_rvalid", 64'(rec_rvalid), 64'd1);
        chk("clr_inflight_rdata",  64'(rdata),      64'h107);
        pb_rd_req = 1'b1; pb_rd_addr = 7'd3;
        #1;
        busyCnt = 0; doneCnt = 0; gntBusy = 0;
        for (int i = 0; i < 120; i++) begin
            if (clear_busy) busyCnt++;
            if (clear_done) doneCnt++;
            if (clear_busy && (rec_rd_gnt || pb_rd_gnt || rec_wr_gnt)) gntBusy++;
            if (i == 10) clear_start = 1'b1;
            if (i == 11) clear_start = 1'b0;
            step();
        end
        rec_rd_req = 1'b0; pb_rd_req = 1'b0;
        step();
        chk("clr_busy_cycles", 64'(busyCnt), 64'd101);
        chk("clr_done_pulses", 64'(doneCnt), 64'd1);
        chk("clr_gnt_in_busy", 64'(gntBusy), 64'd0);
        nonZero = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rdSlot(7'(i), d);
            if (d != '0) nonZero++;
        end
        chk("clr_nonzero_slots", 64'(nonZero), 64'd0);

        // Reset during clear cycle 50: abort, no done, slot 60 untouched
        wrSlot(7'd60, 62'hABC);
        wrSlot(7'd10, 62'hBBB);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (49) step();
        chk("rstclr_busy_before", 64'(clear_busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstclr_busy_after", 64'(clear_busy), 64'd0);
        doneCnt = 0; busyCnt = 0;
        for (int i = 0; i < 110; i++) begin
            if (clear_done) doneCnt++;
            if (clear_busy) busyCnt++;
            step();
        end
        chk("rstclr_no_done", 64'(doneCnt), 64'd0);
        chk("rstclr_no_busy", 64'(busyCnt), 64'd0);
        rdSlot(7'd60, d);
        chk("rstclr_slot60", 64'(d), 64'hABC);
        rdSlot(7'd10, d);
        chk("rstclr_slot10", 64'(d), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
